fixed_to_fp_iter: RTL and testbench

FIXED_TO_FP_ITER -- requirements
Module: fixed_to_fp_iter

---
 rtl/fixed_to_fp_pkg.sv | 15 +
 rtl/fixed_to_fp_iter.sv | 88 ++++++++
 tb/tb_fixed_to_fp_iter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fixed_to_fp_pkg.sv
// Shared widths, exponent bias and FSM state type for the fixed-to-float converter.
package fixed_to_fp_pkg;

  localparam int unsigned FRAC_W = 19;
  localparam int unsigned MAG_W  = 20;
  localparam int unsigned FP_W   = 32;
  localparam logic [7:0]  EXP_BIAS = 8'd127;

  typedef enum logic [1:0] {
    StIdle,
    StNorm,
    StDone
  } state_e;

endpackage

// File: rtl/fixed_to_fp_iter.sv
// Sign-magnitude 1.19 fixed point to IEEE-754 single, normalized one bit per cycle.
module fixed_to_fp_iter
  import fixed_to_fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sign_i,
  input  logic              integer_i,
  input  logic [FRAC_W-1:0] fractional_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FP_W-1:0]   fp_o
);

  state_e             state_q, state_d;
  logic               sign_q, sign_d;
  logic [MAG_W-1:0]   mag_q, mag_d;
  logic [7:0]         exp_q, exp_d;
  logic [FP_W-1:0]    fp_q, fp_d;
  logic               ready_q;
  logic [MAG_W-1:0]   in_mag;
  logic               accept;

  // ready_q keeps in_ready low until the first clock edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      exp_q   <= '0;
      fp_q    <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      exp_q   <= exp_d;
      fp_q    <= fp_d;
      ready_q <= 1'b1;
    end
  end

  assign in_mag    = {integer_i, fractional_i};
  assign in_ready  = (state_q == StIdle) && ready_q;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == StDone);
  assign fp_o      = fp_q;

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    exp_d   = exp_q;
    fp_d    = fp_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          sign_d = sign_i;
          mag_d  = in_mag;
          exp_d  = EXP_BIAS;
          if (in_mag == '0) begin
            fp_d    = '0;
            state_d = StDone;
          end else begin
            state_d = StNorm;
          end
        end
      end
      StNorm: begin
        if (mag_q[MAG_W-1]) begin
          // hidden bit dropped; 19 remaining bits land at the top of the 23-bit mantissa
          fp_d    = {sign_q, exp_q, mag_q[MAG_W-2:0], 4'b0000};
          state_d = StDone;
        end else begin
          mag_d = {mag_q[MAG_W-2:0], 1'b0};
          exp_d = exp_q - 8'd1;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_fixed_to_fp_iter.sv
// Scoreboard bench for fixed_to_fp_iter: expected results queued at drive time, popped on output.
module tb_fixed_to_fp_iter;

  typedef struct {
    logic [31:0] fp;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        sign_i;
  logic        integer_i;
  logic [18:0] fractional_i;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] fp_o;

  int   n_tests;
  int   n_fail;
  exp_t sb[$];

  fixed_to_fp_iter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .sign_i       (sign_i),
    .integer_i    (integer_i),
    .fractional_i (fractional_i),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .fp_o         (fp_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: find leading one, scale exponent, drop hidden bit.
  function automatic exp_t model(input logic s, input logic [19:0] m);
    exp_t        r;
    int          k;
    logic [19:0] t;
    if (m == 20'd0) begin
      r.fp  = 32'h0;
      r.lat = 1;
    end else begin
      k = 0;
      t = m;
      while (!t[19]) begin
        t = t << 1;
        k++;
      end
      r.fp  = {s, 8'(127 - k), t[18:0], 4'b0000};
      r.lat = k + 2;
    end
    return r;
  endfunction

  task automatic send(input logic s, input logic i, input logic [18:0] f);
    int cnt;
    cnt = 0;
    while (!in_ready && cnt < 60) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    sign_i       = s;
    integer_i    = i;
    fractional_i = f;
    in_valid     = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Called #1 after the accept edge; lat counts cycles until out_valid, bounded.
  task automatic collect(output logic [31:0] fp, output int lat);
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    fp = fp_o;
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || fp_o !== 32'h0) begin
      $display("FAIL reset_hold: in_ready=%b out_valid=%b fp_o=%h, want 0 0 00000000",
               in_ready, out_valid, fp_o);
      n_fail++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b0) begin
      $display("FAIL reset_release_pre_edge: in_ready=%b want 0", in_ready);
      n_fail++;
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_first_edge: in_ready=%b want 1", in_ready);
      n_fail++;
    end
  endtask

  task automatic test_directed();
    logic        s_t[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        i_t[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [18:0] f_t[5]  = '{19'h0, 19'h40000, 19'h40000, 19'h00001, 19'h0};
    logic [31:0] fp_t[5] = '{32'h3F800000, 32'hBFC00000, 32'h3F000000, 32'h36000000, 32'h0};
    int          l_t[5]  = '{2, 2, 3, 21, 1};
    logic [31:0] fp;
    int          lat;
    exp_t        e;
    for (int n = 0; n < 5; n++) begin
      e.fp  = fp_t[n];
      e.lat = l_t[n];
      sb.push_back(e);
      send(s_t[n], i_t[n], f_t[n]);
      collect(fp, lat);
      e = sb.pop_front();
      n_tests++;
      if (fp !== e.fp || lat !== e.lat) begin
        $display("FAIL directed_%0d: fp_o=%h lat=%0d, want %h lat=%0d", n, fp, lat, e.fp, e.lat);
        n_fail++;
      end
      take();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] fp;
    int          lat;
    exp_t        e;
    e = model(1'b0, {1'b1, 19'h12345});
    sb.push_back(e);
    send(1'b0, 1'b1, 19'h12345);
    collect(fp, lat);
    e = sb.pop_front();
    n_tests++;
    if (fp !== e.fp || lat !== e.lat) begin
      $display("FAIL bp_result: fp_o=%h lat=%0d, want %h lat=%0d", fp, lat, e.fp, e.lat);
      n_fail++;
    end
    in_valid     = 1'b1;
    sign_i       = 1'b1;
    integer_i    = 1'b0;
    fractional_i = 19'h00777;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if (fp_o !== e.fp || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        $display("FAIL bp_hold_%0d: fp_o=%h out_valid=%b in_ready=%b, want %h 1 0",
                 c, fp_o, out_valid, in_ready, e.fp);
        n_fail++;
      end
    end
    in_valid = 1'b0;
    take();
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || fp_o !== e.fp) begin
      $display("FAIL bp_release: out_valid=%b in_ready=%b fp_o=%h, want 0 1 %h",
               out_valid, in_ready, fp_o, e.fp);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] fp;
    int          lat;
    int          stale;
    exp_t        e;
    send(1'b0, 1'b0, 19'h00001);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || fp_o !== 32'h0 || in_ready !== 1'b0) begin
      $display("FAIL reset_mid_async: out_valid=%b fp_o=%h in_ready=%b, want 0 00000000 0",
               out_valid, fp_o, in_ready);
      n_fail++;
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) stale++;
    end
    n_tests++;
    if (stale !== 0) begin
      $display("FAIL reset_mid_stale: out_valid cycles=%0d want 0", stale);
      n_fail++;
    end
    e.fp  = 32'hBF000000;
    e.lat = 3;
    sb.push_back(e);
    send(1'b1, 1'b0, 19'h40000);
    collect(fp, lat);
    e = sb.pop_front();
    n_tests++;
    if (fp !== e.fp || lat !== e.lat) begin
      $display("FAIL reset_mid_next: fp_o=%h lat=%0d, want %h lat=%0d", fp, lat, e.fp, e.lat);
      n_fail++;
    end
    take();
  endtask

  task automatic test_back_to_back();
    logic        s;
    logic [19:0] m;
    logic [31:0] fp;
    int          lat;
    exp_t        e;
    for (int n = 0; n < 10; n++) begin
      s = 1'($urandom);
      m = 20'($urandom) >> $urandom_range(0, 19);
      if (n == 3) m = 20'h0;
      sb.push_back(model(s, m));
      send(s, m[19], m[18:0]);
      collect(fp, lat);
      e = sb.pop_front();
      n_tests++;
      if (fp !== e.fp || lat !== e.lat) begin
        $display("FAIL b2b_%0d: mag=%h sign=%b fp_o=%h lat=%0d, want %h lat=%0d",
                 n, m, s, fp, lat, e.fp, e.lat);
        n_fail++;
      end
      take();
      n_tests++;
      if (in_ready !== 1'b1) begin
        $display("FAIL b2b_ready_%0d: in_ready=%b want 1", n, in_ready);
        n_fail++;
      end
    end
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    sign_i       = 1'b0;
    integer_i    = 1'b0;
    fractional_i = '0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
